// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder for the RV32I core: accepts one load/store request at
// a time, inserts WAIT_STATES wait cycles, performs byte-masked writes into a
// word array or returns a registered read word, and pulses ack for one cycle.
module msrv32_dmem_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h00010000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        dmem_rd_req_in,
    input  logic        dmem_wr_req_in,
    input  logic [31:0] dmem_addr_in,
    input  logic [31:0] dmem_wdata_in,
    input  logic [3:0]  dmem_wr_mask_in,
    output logic [31:0] dmem_rdata_out,
    output logic        dmem_ack_out,
    output logic        dmem_err_out,
    output logic        dmem_busy_out
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CW      = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS) << 2;
    localparam logic [CW-1:0] WS_LOAD = CW'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;

    // Request attributes captured at acceptance
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_mask;
    logic            lat_wr;
    logic            lat_err;

    logic [31:0]     mem [0:DEPTH_WORDS-1];

    logic            req_any;
    logic [31:0]     in_offset;
    logic            in_err;
    logic [AW-1:0]   in_idx;

    // Attributes used on the edge entering RESP (live inputs when WAIT is skipped)
    logic            sel_err;
    logic            sel_wr;
    logic [AW-1:0]   sel_idx;
    logic            enter_resp;

    // Merge the enabled byte lanes of new data over the old word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

    // Decode the incoming request: the unsigned offset wraps for addresses
    // below the base, so a single compare covers both ends of the window
    always_comb begin
        req_any    = dmem_rd_req_in | dmem_wr_req_in;
        in_offset  = dmem_addr_in - BASE_ADDRESS;
        in_err     = (in_offset >= SPAN) | (dmem_rd_req_in & dmem_wr_req_in);
        in_idx     = in_offset[AW+1:2];
        sel_err    = (state == IDLE) ? in_err         : lat_err;
        sel_wr     = (state == IDLE) ? dmem_wr_req_in : lat_wr;
        sel_idx    = (state == IDLE) ? in_idx         : lat_idx;
        enter_resp = (state_next == RESP) && (state != RESP);
    end

    // Next-state logic for IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_any) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: if (cnt == CW'(1)) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, wait counter, error/op flags and registered read data
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_wr         <= 1'b0;
            lat_err        <= 1'b0;
            dmem_rdata_out <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_any) begin
                cnt     <= WS_LOAD;
                lat_wr  <= dmem_wr_req_in;
                lat_err <= in_err;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (enter_resp) begin
                if (sel_err)      dmem_rdata_out <= 32'h0;
                else if (!sel_wr) dmem_rdata_out <= mem[sel_idx];
            end
        end
    end

    // Request payload is captured without reset; it is only consumed after acceptance
    always_ff @(posedge clk_in) begin
        if (state == IDLE && req_any) begin
            lat_idx   <= in_idx;
            lat_wdata <= dmem_wdata_in;
            lat_mask  <= dmem_wr_mask_in;
        end
    end

    // Commit the store on the edge leaving RESP unless reset cancels it
    always_ff @(posedge clk_in) begin
        if (!reset_in && state == RESP && lat_wr && !lat_err) begin
            mem[lat_idx] <= merge_lanes(mem[lat_idx], lat_wdata, lat_mask);
        end
    end

    assign dmem_ack_out  = (state == RESP);
    assign dmem_err_out  = (state == RESP) & lat_err;
    assign dmem_busy_out = (state != IDLE);

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Self-checking bench for msrv32_dmem_responder: one instance with two wait
// states and one with none, each compared with a transaction-level memory model.
module tb_msrv32_dmem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h00010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [3:0]  mask_a, mask_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;

    msrv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDRESS(BASE)) dut_a (
        .clk_in(clk), .reset_in(rst),
        .dmem_rd_req_in(rd_a), .dmem_wr_req_in(wr_a), .dmem_addr_in(addr_a),
        .dmem_wdata_in(wdata_a), .dmem_wr_mask_in(mask_a),
        .dmem_rdata_out(rdata_a), .dmem_ack_out(ack_a), .dmem_err_out(err_a),
        .dmem_busy_out(busy_a)
    );

    msrv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDRESS(BASE)) dut_b (
        .clk_in(clk), .reset_in(rst),
        .dmem_rd_req_in(rd_b), .dmem_wr_req_in(wr_b), .dmem_addr_in(addr_b),
        .dmem_wdata_in(wdata_b), .dmem_wr_mask_in(mask_b),
        .dmem_rdata_out(rdata_b), .dmem_ack_out(ack_b), .dmem_err_out(err_b),
        .dmem_busy_out(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [31:0] exp_mem [2][DEPTH];
    logic [31:0] exp_rd  [2];
    int          ws      [2] = '{2, 0};

    logic        m_ack, m_err, m_busy;
    logic [31:0] m_rdata;
    assign m_ack   = (sel != 0) ? ack_b   : ack_a;
    assign m_err   = (sel != 0) ? err_b   : err_a;
    assign m_busy  = (sel != 0) ? busy_b  : busy_a;
    assign m_rdata = (sel != 0) ? rdata_b : rdata_a;

    task automatic set_in(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        if (sel == 0) begin
            rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wdata; mask_a = mask;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = wdata; mask_b = mask;
        end
    endtask

    // One complete transaction on the selected instance, started in an IDLE cycle
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       output logic [31:0] got);
        logic [31:0] off, exp_data;
        logic        exp_err;
        int          n, idx;
        off     = addr - BASE;
        exp_err = (off >= 32'(DEPTH * 4)) || (rd && wr);
        idx     = int'(off >> 2);
        if (exp_err)  exp_data = 32'h0;
        else if (rd)  exp_data = exp_mem[sel][idx];
        else          exp_data = exp_rd[sel];
        set_in(rd, wr, addr, wdata, mask);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!m_ack) set_in(rd, wr, $urandom, $urandom, 4'($urandom));
        end while (!m_ack && n < 40);
        checks++;
        if (n != ws[sel] + 1) begin
            errors++;
            $display("FAIL latency dut%0d addr=%h got %0d cycles want %0d", sel, addr, n, ws[sel] + 1);
        end
        checks++;
        if (m_err !== exp_err) begin
            errors++;
            $display("FAIL err dut%0d addr=%h rd=%b wr=%b got %b want %b", sel, addr, rd, wr, m_err, exp_err);
        end
        checks++;
        if (m_rdata !== exp_data) begin
            errors++;
            $display("FAIL rdata dut%0d addr=%h got %h want %h", sel, addr, m_rdata, exp_data);
        end
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ack dut%0d got %b want 1", sel, m_busy);
        end
        got = m_rdata;
        set_in(1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
        exp_rd[sel] = exp_data;
        if (!exp_err && wr) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) exp_mem[sel][idx][8*i +: 8] = wdata[8*i +: 8];
        end
        @(negedge clk);
        checks++;
        if (m_ack !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after dut%0d ack=%b busy=%b want 0 0", sel, m_ack, m_busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0; mask_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0; mask_b = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_a, err_a, busy_a} !== 3'b000 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_a ack/err/busy=%b%b%b rdata=%h want 000 0", ack_a, err_a, busy_a, rdata_a);
        end
        checks++;
        if ({ack_b, err_b, busy_b} !== 3'b000 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_b ack/err/busy=%b%b%b rdata=%h want 000 0", ack_b, err_b, busy_b, rdata_b);
        end
        rst = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_init;
        logic [31:0] g;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < DEPTH; w++)
                txn(1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, g);
        end
        sel = 0;
    endtask

    task automatic test_directed;
        logic [31:0] g;
        sel = 0;
        txn(1'b0, 1'b1, BASE + 32'd8, 32'hDEADBEEF, 4'hF, g);
        txn(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, g);
        checks++;
        if (g !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL readback got %h want deadbeef", g);
        end
        txn(1'b0, 1'b1, BASE + 32'd20, 32'h11223344, 4'hF, g);
        txn(1'b0, 1'b1, BASE + 32'd20, 32'h000000AA, 4'b0001, g);
        txn(1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0, g);
        checks++;
        if (g !== 32'h112233AA) begin
            errors++;
            $display("FAIL byte_mask got %h want 112233aa", g);
        end
        txn(1'b0, 1'b1, BASE + 32'd24, 32'h55555555, 4'b0000, g);
        txn(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, g);
        txn(1'b1, 1'b0, BASE - 32'd4, 32'h0, 4'h0, g);
        txn(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, g);
        txn(1'b1, 1'b1, BASE, 32'hA5A5A5A5, 4'hF, g);
        txn(1'b1, 1'b0, BASE, 32'h0, 4'h0, g);
    endtask

    task automatic test_random;
        logic [31:0] g, addr;
        logic        rd, wr;
        int          r;
        sel = 0;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            else             addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            rd = (r <= 4);
            wr = (r == 0) || (r >= 5);
            txn(rd, wr, addr, $urandom, 4'($urandom), g);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [7];
        sel = 1;
        for (int k = 0; k < 7; k++) a[k] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        set_in(1'b1, 1'b0, a[0], 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (ack_b !== 1'b1 || err_b !== 1'b0 || busy_b !== 1'b1 ||
                rdata_b !== exp_mem[1][int'((a[k] - BASE) >> 2)]) begin
                errors++;
                $display("FAIL b2b_ack k=%0d ack=%b err=%b busy=%b rdata=%h want 1 0 1 %h",
                         k, ack_b, err_b, busy_b, rdata_b, exp_mem[1][int'((a[k] - BASE) >> 2)]);
            end
            exp_rd[1] = exp_mem[1][int'((a[k] - BASE) >> 2)];
            set_in(1'b1, 1'b0, a[k+1], 32'h0, 4'h0);
            @(negedge clk);
            checks++;
            if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap k=%0d ack=%b busy=%b want 0 0", k, ack_b, busy_b);
            end
        end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        sel = 0;
    endtask

    task automatic test_reset_midway;
        logic [31:0] g;
        int          n, acks;
        sel = 0;
        // Reset during WAIT of a write
        set_in(1'b0, 1'b1, BASE + 32'd12, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        checks++;
        if ({ack_a, err_a, busy_a} !== 3'b000 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait ack/err/busy=%b%b%b rdata=%h want 000 0", ack_a, err_a, busy_a, rdata_a);
        end
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL rst_noack got %0d acks want 0", acks);
        end
        txn(1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0, g);
        // Reset coinciding with the edge leaving RESP of a write
        set_in(1'b0, 1'b1, BASE + 32'd16, 32'h0BADF00D, 4'hF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_a && n < 40);
        checks++;
        if (!ack_a) begin
            errors++;
            $display("FAIL rst_resp_ack got 0 want 1");
        end
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        txn(1'b1, 1'b0, BASE + 32'd16, 32'h0, 4'h0, g);
    endtask

    task automatic test_scan;
        logic [31:0] g;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < DEPTH; w++)
                txn(1'b1, 1'b0, BASE + 32'(4 * w), 32'h0, 4'h0, g);
        end
        sel = 0;
    endtask

    initial begin
        test_reset;
        test_init;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_midway;
        test_scan;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
